// File: rtl/load_wb_ctrl.sv
// rtl/load_wb_ctrl.sv - write-back controller for ALU results and memory loads
module load_wb_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [2:0]  i_reg_wr_sel,
    input  logic [4:0]  i_rd,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_data,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
    output logic        o_rf_wen,
    output logic [4:0]  o_rf_waddr,
    output logic [31:0] o_rf_wdata,
    output logic        o_busy,
    output logic        o_err
);

    localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT_CYCLES);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    logic [4:0]  r_rd;
    logic [2:0]  r_funct3;
    logic [1:0]  r_addr_lo;
    logic [7:0]  r_cnt;
    logic        r_rf_wen;
    logic [4:0]  r_rf_waddr;
    logic [31:0] r_rf_wdata;
    logic        r_err;

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [7:0]  w_cnt_inc;

    assign w_cnt_inc = r_cnt + 8'd1;

    // Pick the addressed byte/halfword of the memory word and extend it per load width
    always_comb begin
        w_byte = 8'd0;
        case (r_addr_lo)
            2'd0:    w_byte = i_mem_rdata[7:0];
            2'd1:    w_byte = i_mem_rdata[15:8];
            2'd2:    w_byte = i_mem_rdata[23:16];
            default: w_byte = i_mem_rdata[31:24];
        endcase
        w_half = r_addr_lo[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load_data = {24'd0, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b101:  w_load_data = {16'd0, w_half};
            default: w_load_data = i_mem_rdata;
        endcase
    end

    // Request acceptance, memory wait with timeout, and registered write-back/error pulses
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_rd       <= 5'd0;
            r_funct3   <= 3'd0;
            r_addr_lo  <= 2'd0;
            r_cnt      <= 8'd0;
            r_rf_wen   <= 1'b0;
            r_rf_waddr <= 5'd0;
            r_rf_wdata <= 32'd0;
            r_err      <= 1'b0;
        end else begin
            r_rf_wen <= 1'b0;
            r_err    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_valid) begin
                        case (i_reg_wr_sel)
                            3'b000: begin
                                r_rd      <= i_rd;
                                r_funct3  <= i_funct3;
                                r_addr_lo <= i_addr_lo;
                                r_cnt     <= 8'd0;
                                r_state   <= ST_WAIT;
                            end
                            3'b001, 3'b010, 3'b011, 3'b100: begin
                                r_rf_wen   <= (i_rd != 5'd0);
                                r_rf_waddr <= i_rd;
                                r_rf_wdata <= i_data;
                            end
                            default: begin
                                r_err <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_WAIT: begin
                    // rvalid takes priority over the timeout landing in the same cycle
                    if (i_mem_rvalid) begin
                        r_rf_wen   <= (r_rd != 5'd0);
                        r_rf_waddr <= r_rd;
                        r_rf_wdata <= w_load_data;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == LP_TIMEOUT) begin
                            r_err   <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_ready    = (r_state == ST_IDLE);
    assign o_busy     = (r_state == ST_WAIT);
    assign o_rf_wen   = r_rf_wen;
    assign o_rf_waddr = r_rf_waddr;
    assign o_rf_wdata = r_rf_wdata;
    assign o_err      = r_err;

endmodule

// File: tb/tb_load_wb_ctrl.sv
// tb/tb_load_wb_ctrl.sv - randomized self-checking bench for load_wb_ctrl
module tb_load_wb_ctrl;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        ready;
    logic [2:0]  sel = 3'd0;
    logic [4:0]  rd = 5'd0;
    logic [2:0]  funct3 = 3'd0;
    logic [1:0]  addr_lo = 2'd0;
    logic [31:0] data = 32'd0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = 32'd0;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        busy;
    logic        err;

    int n_vec = 0;
    int n_bad = 0;

    load_wb_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready),
        .i_reg_wr_sel(sel), .i_rd(rd), .i_funct3(funct3), .i_addr_lo(addr_lo),
        .i_data(data), .i_mem_rvalid(rvalid), .i_mem_rdata(rdata),
        .o_rf_wen(wen), .o_rf_waddr(waddr), .o_rf_wdata(wdata),
        .o_busy(busy), .o_err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // advance one clock; outputs are then sampled 1ns after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference load extraction from the ISA rules using plain arithmetic
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
        longint b, h;
        b = (longint'(w) >> (8 * int'(a))) % 256;
        h = (longint'(w) >> (16 * (int'(a) / 2))) % 65536;
        case (f3)
            3'd0: return 32'((b >= 128) ? b - 256 : b);
            3'd4: return 32'(b);
            3'd1: return 32'((h >= 32768) ? h - 65536 : h);
            3'd5: return 32'(h);
            default: return w;
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1; valid = 1'b0; rvalid = 1'b0;
        cyc(); cyc();
        n_vec++;
        if ({wen, err, ready, busy} !== 4'b0010 || waddr !== 5'd0 || wdata !== 32'd0) begin
            n_bad++;
            $display("FAIL reset: wen/err/ready/busy=%b waddr=%0d wdata=%h, want 0010 0 0", {wen, err, ready, busy}, waddr, wdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        valid = 1'b1; sel = 3'b001; rd = 5'd5; data = 32'h11;
        cyc();
        n_vec++;
        if ({wen, err, ready} !== 3'b101 || waddr !== 5'd5 || wdata !== 32'h11) begin
            n_bad++;
            $display("FAIL b2b_first: wen/err/ready=%b waddr=%0d wdata=%h, want 101 5 11", {wen, err, ready}, waddr, wdata);
        end
        rd = 5'd6; data = 32'h22;
        cyc();
        valid = 1'b0;
        n_vec++;
        if ({wen, err, ready} !== 3'b101 || waddr !== 5'd6 || wdata !== 32'h22) begin
            n_bad++;
            $display("FAIL b2b_second: wen/err/ready=%b waddr=%0d wdata=%h, want 101 6 22", {wen, err, ready}, waddr, wdata);
        end
        cyc();
        n_vec++;
        if ({wen, err, ready} !== 3'b001) begin
            n_bad++;
            $display("FAIL b2b_after: wen/err/ready=%b, want 001", {wen, err, ready});
        end
    endtask

    // Issue a load, wait `waits` empty cycles, then rvalid; report write seen after rvalid
    task automatic run_load(input string name, input logic [4:0] r, input logic [2:0] f3, input logic [1:0] a,
                            input logic [31:0] w, input int waits);
        int busy_cnt;
        logic [31:0] exp;
        exp = ref_load(f3, a, w);
        valid = 1'b1; sel = 3'b000; rd = r; funct3 = f3; addr_lo = a;
        cyc();
        valid = 1'b0;
        busy_cnt = 0;
        for (int k = 0; k < waits; k++) begin
            if (busy) busy_cnt++;
            cyc();
        end
        if (busy) busy_cnt++;
        rvalid = 1'b1; rdata = w;
        cyc();
        rvalid = 1'b0;
        n_vec++;
        if (busy_cnt !== waits + 1) begin
            n_bad++;
            $display("FAIL %s_busy: busy cycles=%0d, want %0d", name, busy_cnt, waits + 1);
        end
        n_vec++;
        if ({wen, err, ready, busy} !== {(r != 5'd0), 3'b010}) begin
            n_bad++;
            $display("FAIL %s_flags: wen/err/ready/busy=%b, want %b", name, {wen, err, ready, busy}, {(r != 5'd0), 3'b010});
        end
        if (r != 5'd0) begin
            n_vec++;
            if (waddr !== r || wdata !== exp) begin
                n_bad++;
                $display("FAIL %s_data: waddr=%0d wdata=%h, want %0d %h", name, waddr, wdata, r, exp);
            end
        end
    endtask

    task automatic test_loads();
        run_load("lb", 5'd3, 3'b000, 2'd2, 32'h12F45678, 3);
        n_vec++;
        if (ref_load(3'b000, 2'd2, 32'h12F45678) !== 32'hFFFFFFF4) begin
            n_bad++;
            $display("FAIL lb_model: model=%h, want FFFFFFF4", ref_load(3'b000, 2'd2, 32'h12F45678));
        end
        run_load("lhu", 5'd9, 3'b101, 2'd3, 32'hBEEF1234, 1);
        run_load("lhu_x0", 5'd0, 3'b101, 2'd3, 32'hBEEF1234, 0);
        run_load("lw_f3_7", 5'd31, 3'b111, 2'd1, 32'hCAFEF00D, 2);
    endtask

    task automatic test_timeout();
        valid = 1'b1; sel = 3'b000; rd = 5'd4; funct3 = 3'b010;
        cyc();
        valid = 1'b0;
        for (int k = 1; k <= T; k++) begin
            n_vec++;
            if ({wen, err, busy} !== 3'b001) begin
                n_bad++;
                $display("FAIL timeout_wait%0d: wen/err/busy=%b, want 001", k, {wen, err, busy});
            end
            cyc();
        end
        n_vec++;
        if ({wen, err, ready, busy} !== 4'b0110) begin
            n_bad++;
            $display("FAIL timeout_abort: wen/err/ready/busy=%b, want 0110", {wen, err, ready, busy});
        end
        cyc();
        n_vec++;
        if ({wen, err} !== 2'b00) begin
            n_bad++;
            $display("FAIL timeout_err_pulse: wen/err=%b, want 00", {wen, err});
        end
        run_load("rvalid_at_limit", 5'd8, 3'b010, 2'd0, 32'h0BADBEEF, T - 1);
    endtask

    task automatic test_illegal_and_reset();
        valid = 1'b1; sel = 3'b110; rd = 5'd2;
        cyc();
        valid = 1'b0;
        n_vec++;
        if ({wen, err, ready} !== 3'b011) begin
            n_bad++;
            $display("FAIL illegal_sel: wen/err/ready=%b, want 011", {wen, err, ready});
        end
        valid = 1'b1; sel = 3'b000; rd = 5'd12;
        cyc();
        valid = 1'b0; rst = 1'b1;
        cyc();
        rst = 1'b0; rvalid = 1'b1; rdata = 32'h55;
        cyc();
        rvalid = 1'b0;
        n_vec++;
        if ({wen, err, ready, busy} !== 4'b0010) begin
            n_bad++;
            $display("FAIL reset_in_wait: wen/err/ready/busy=%b, want 0010", {wen, err, ready, busy});
        end
    endtask

    task automatic test_valid_in_wait();
        valid = 1'b1; sel = 3'b000; rd = 5'd10; funct3 = 3'b010;
        cyc();
        sel = 3'b001; rd = 5'd7; data = 32'h77;
        cyc();
        rvalid = 1'b1; rdata = 32'h1234;
        cyc();
        valid = 1'b0; rvalid = 1'b0;
        n_vec++;
        if ({wen, err} !== 2'b10 || waddr !== 5'd10 || wdata !== 32'h1234) begin
            n_bad++;
            $display("FAIL valid_in_wait: wen/err=%b waddr=%0d wdata=%h, want 10 10 1234", {wen, err}, waddr, wdata);
        end
        rvalid = 1'b1;
        cyc();
        rvalid = 1'b0;
        n_vec++;
        if ({wen, err, ready} !== 3'b001) begin
            n_bad++;
            $display("FAIL rvalid_in_idle: wen/err/ready=%b, want 001", {wen, err, ready});
        end
    endtask

    // Randomized transactions checked against a transaction-level expectation
    task automatic test_random();
        int kind, w;
        logic [4:0] r;
        logic [31:0] d, m, exp;
        logic [2:0] f3;
        logic [1:0] a;
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 9);
            r = 5'($urandom_range(0, 31));
            d = $urandom;
            if (kind < 4) begin
                valid = 1'b1; sel = 3'($urandom_range(1, 4)); rd = r; data = d;
                cyc();
                valid = 1'b0;
                n_vec++;
                if ({wen, err, ready} !== {(r != 5'd0), 2'b01} || (r != 5'd0 && (waddr !== r || wdata !== d))) begin
                    n_bad++;
                    $display("FAIL rnd_alu%0d: wen/err/ready=%b waddr=%0d wdata=%h, want rd=%0d data=%h", n, {wen, err, ready}, waddr, wdata, r, d);
                end
            end else if (kind == 4) begin
                valid = 1'b1; sel = 3'($urandom_range(5, 7)); rd = r;
                cyc();
                valid = 1'b0;
                n_vec++;
                if ({wen, err, ready} !== 3'b011) begin
                    n_bad++;
                    $display("FAIL rnd_illegal%0d: wen/err/ready=%b, want 011", n, {wen, err, ready});
                end
            end else if (kind == 5) begin
                valid = 1'b0; rvalid = 1'($urandom_range(0, 1)); rdata = d;
                cyc();
                rvalid = 1'b0;
                n_vec++;
                if ({wen, err, ready} !== 3'b001) begin
                    n_bad++;
                    $display("FAIL rnd_idle%0d: wen/err/ready=%b, want 001", n, {wen, err, ready});
                end
            end else begin
                f3 = 3'($urandom_range(0, 7)); a = 2'($urandom_range(0, 3));
                m = $urandom; w = $urandom_range(0, T + 1);
                exp = ref_load(f3, a, m);
                valid = 1'b1; sel = 3'b000; rd = r; funct3 = f3; addr_lo = a;
                cyc();
                for (int k = 1; k <= T; k++) begin
                    valid = 1'($urandom_range(0, 1)); sel = 3'b001; rd = 5'd1; data = 32'hDEAD0000;
                    rvalid = (k == w + 1); rdata = rvalid ? m : $urandom;
                    cyc();
                    if (rvalid) begin
                        valid = 1'b0; rvalid = 1'b0;
                        n_vec++;
                        if ({wen, err, ready} !== {(r != 5'd0), 2'b01} || (r != 5'd0 && (waddr !== r || wdata !== exp))) begin
                            n_bad++;
                            $display("FAIL rnd_load%0d: wen/err/ready=%b waddr=%0d wdata=%h, want rd=%0d data=%h", n, {wen, err, ready}, waddr, wdata, r, exp);
                        end
                        break;
                    end else if (k == T) begin
                        valid = 1'b0;
                        n_vec++;
                        if ({wen, err, ready} !== 3'b011) begin
                            n_bad++;
                            $display("FAIL rnd_timeout%0d: wen/err/ready=%b, want 011", n, {wen, err, ready});
                        end
                    end else begin
                        n_vec++;
                        if ({wen, err, busy} !== 3'b001) begin
                            n_bad++;
                            $display("FAIL rnd_wait%0d: wen/err/busy=%b, want 001", n, {wen, err, busy});
                        end
                    end
                end
                valid = 1'b0; rvalid = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_loads();
        test_timeout();
        test_illegal_and_reset();
        test_valid_in_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/load_wb_ctrl.md
LOAD_WB_CTRL -- requirements
Module: load_wb_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: maximum WAIT_MEM cycles before abort; legal range 1..255.
REQ-002 i_clk  in  1  single clock; all state updates on the rising edge.
REQ-003 i_rst  in  1  synchronous, active-high reset.
REQ-004 i_valid  in  1  a write-back request is presented this cycle.
REQ-005 o_ready  out  1  the controller accepts a request this cycle; handshake fires when i_valid && o_ready.
REQ-006 i_reg_wr_sel  in  3  source select: 000 mem, 001 alu, 010 pc_immed, 011 immed, 100 next_pc, 101-111 illegal.
REQ-007 i_rd  in  5  destination register index.
REQ-008 i_funct3  in  3  load width: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-009 i_addr_lo  in  2  low bits of the load byte address.
REQ-010 i_data  in  32  precomputed non-memory result for selects 001-100.
REQ-011 i_mem_rvalid  in  1  memory read data is valid this cycle.
REQ-012 i_mem_rdata  in  32  memory read word, aligned.
REQ-013 o_rf_wen  out  1  register-file write enable, one-cycle pulse.
REQ-014 o_rf_waddr  out  5  register-file write address.
REQ-015 o_rf_wdata  out  32  register-file write data.
REQ-016 o_busy  out  1  high while in WAIT_MEM.
REQ-017 o_err  out  1  one-cycle pulse on an illegal select or a timeout.

Function
REQ-018 The FSM shall have two states: IDLE and WAIT_MEM; o_ready = (state == IDLE); o_busy = (state == WAIT_MEM).
REQ-019 On a handshake with select 001-100, the controller shall stay in IDLE and, on the next cycle, drive o_rf_wen=1, o_rf_waddr=i_rd, o_rf_wdata=i_data (all registered), giving one request per cycle throughput.
REQ-020 On a handshake with select 000, the controller shall latch i_rd, i_funct3 and i_addr_lo, clear the timeout counter and enter WAIT_MEM.
REQ-021 In WAIT_MEM, the cycle i_mem_rvalid=1 shall extract the data and return to IDLE; o_rf_wen pulses on the following cycle, the same cycle o_ready rises.
REQ-022 Extraction: LB/LBU select byte i_addr_lo and sign- or zero-extend it; LH/LHU select halfword i_addr_lo[1] (i_addr_lo[0] ignored) and sign- or zero-extend it; LW passes the word unchanged; funct3 011, 110 and 111 are treated as LW.
REQ-023 If rd == 0, o_rf_wen shall stay 0; sequencing and timing are otherwise unchanged.
REQ-024 An illegal select (101-111) shall be accepted, leave the state in IDLE, produce no write, and pulse o_err on the next cycle.
REQ-025 The timeout counter (8 bits) shall increment each WAIT_MEM cycle without rvalid; on reaching TIMEOUT_CYCLES, the controller shall return to IDLE, pulse o_err on the next cycle and produce no write.
REQ-026 If rvalid arrives in the same cycle the count reaches TIMEOUT_CYCLES, rvalid shall win: a normal write with no o_err.
REQ-027 i_mem_rvalid in IDLE shall be ignored; i_valid in WAIT_MEM shall not be accepted and no input state shall change.
REQ-028 o_rf_wen and o_err shall be 0 in every cycle not explicitly specified above.

Reset
REQ-029 While i_rst=1 at an edge: state=IDLE, counter=0, o_rf_wen=0, o_rf_waddr=0, o_rf_wdata=0, o_err=0; o_busy=0 and o_ready=1 after the edge.
REQ-030 Reset during WAIT_MEM shall drop the pending load; a later i_mem_rvalid shall produce no write.

Verification
REQ-031 Back-to-back ALU requests (sel=001, rd=5, data=0x11, then rd=6, data=0x22) -> o_rf_wen on the two following cycles with (5, 0x11) then (6, 0x22); o_ready stays high.
REQ-032 LB with rd=3, addr_lo=2, rdata=0x12F45678 after 3 wait cycles -> write of 0xFFFFFFF4 to x3 one cycle after rvalid; o_busy high for exactly the wait cycles plus the rvalid cycle.
REQ-033 LHU with addr_lo=3, rdata=0xBEEF1234 -> write of 0x0000BEEF; the same load with rd=0 -> no o_rf_wen, o_ready returns.
REQ-034 TIMEOUT_CYCLES=4 with no rvalid -> o_err pulse, no write, o_ready high again; a repeat run with rvalid on the 4th wait cycle -> normal write, no o_err.
REQ-035 Request with sel=110 -> o_err pulse, no write; reset asserted in WAIT_MEM followed by rvalid -> no write, o_ready=1.
